regfile_wb_arbiter: RTL and testbench

Writeback scheduler for the 32x32 integer register file, which has a single write port and x0 hardwired to zero. It shares that write port between the ALU writeback path and the load writeback path using round-robin arbitration, and registers the granted write onto the register-file port. It also keeps a scoreboard of registers with outstanding loads and raises a decode-stage hazard when a source operand is not yet valid.

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback scheduler: round-robin share of the register-file write port between ALU and load
// paths, registered write output, and a load scoreboard for decode hazards. Option: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            iss_load,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic            fwd_rs1_en,
  output logic            fwd_rs2_en,
  output logic [XLEN-1:0] fwd_data,
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wr_data
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [AW-1:0]     rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wr_data_q, rf_wr_data_d;

  logic              alu_xfer, ld_xfer, any_xfer;
  logic [AW-1:0]     win_rd;
  logic [XLEN-1:0]   win_data;

  // On contention the requester not granted last wins; a lone requester always wins.
  assign alu_ready = !rst && alu_valid && (!ld_valid || (last_grant_q == GNT_LD));
  assign ld_ready  = !rst && ld_valid && (!alu_valid || (last_grant_q == GNT_ALU));
  assign alu_xfer  = alu_valid && alu_ready;
  assign ld_xfer   = ld_valid && ld_ready;
  assign any_xfer  = alu_xfer || ld_xfer;

  always_comb begin
    win_rd   = ld_rd;
    win_data = ld_data;
    if (alu_xfer) begin
      win_rd   = alu_rd;
      win_data = alu_data;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_xfer) begin
      last_grant_d = GNT_ALU;
    end else if (ld_xfer) begin
      last_grant_d = GNT_LD;
    end
  end

  // Writes to x0 are accepted but dropped: the port registers keep their last contents.
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wr_data_d = rf_wr_data_q;
    if (any_xfer && (win_rd != '0)) begin
      rf_wr_en_d   = 1'b1;
      rf_rd_d      = win_rd;
      rf_wr_data_d = win_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pending_d[gi] = 1'b0;
      end else begin : g_bit
        logic set_hit, clr_hit;
        assign set_hit = iss_load && (iss_rd == AW'(gi));
        assign clr_hit = ld_xfer && (ld_rd == AW'(gi));
        // A same-cycle issue re-arms the bit even if its older load retires now.
        assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_LD;
      pending_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_q      <= '0;
      rf_wr_data_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_q      <= rf_rd_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wr_data = rf_wr_data_q;

  logic pend_rs1, pend_rs2, fly_rs1, fly_rs2;
  assign pend_rs1 = (rs1 != '0) && pending_q[rs1];
  assign pend_rs2 = (rs2 != '0) && pending_q[rs2];
  assign fly_rs1  = rf_wr_en_q && (rf_rd_q != '0) && (rf_rd_q == rs1);
  assign fly_rs2  = rf_wr_en_q && (rf_rd_q != '0) && (rf_rd_q == rs2);

`ifdef REGFILE_WB_BYPASS_EN
  assign hazard     = !rst && (pend_rs1 || pend_rs2);
  assign fwd_rs1_en = !rst && fly_rs1;
  assign fwd_rs2_en = !rst && fly_rs2;
  assign fwd_data   = rst ? '0 : rf_wr_data_q;
`else
  // Without a bypass, a write still sitting in the output register must stall decode.
  assign hazard     = !rst && (pend_rs1 || pend_rs2 || fly_rs1 || fly_rs2);
  assign fwd_rs1_en = 1'b0;
  assign fwd_rs2_en = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then random traffic,
// all compared against a behavioural model of the writeback scheduler.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, ld_valid, iss_load;
  logic [4:0]  alu_rd, ld_rd, iss_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, hazard, fwd_rs1_en, fwd_rs2_en, rf_wr_en;
  logic [31:0] fwd_data, rf_wr_data;
  logic [4:0]  rf_rd;

  int checks = 0;
  int errors = 0;

  // Reference state: who won the last transfer, outstanding loads, write-port register.
  bit          m_last_was_load;
  bit          m_pend [32];
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .iss_load(iss_load), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .fwd_rs1_en(fwd_rs1_en), .fwd_rs2_en(fwd_rs2_en), .fwd_data(fwd_data),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the edge,
  // then check the registered write port just after it.
  task automatic step();
    bit          g_alu, g_ld, hz, f1, f2, fly1, fly2;
    logic [31:0] fd;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    @(negedge clk);
    g_alu = 0;
    g_ld  = 0;
    if (!rst) begin
      if (alu_valid && ld_valid) begin
        g_alu = m_last_was_load;
        g_ld  = !m_last_was_load;
      end else begin
        g_alu = alu_valid;
        g_ld  = ld_valid;
      end
    end
    fly1 = m_wen && m_rd != 0 && m_rd == rs1;
    fly2 = m_wen && m_rd != 0 && m_rd == rs2;
    hz   = (rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]);
`ifdef REGFILE_WB_BYPASS_EN
    f1 = fly1;
    f2 = fly2;
    fd = m_data;
`else
    hz = hz || fly1 || fly2;
    f1 = 0;
    f2 = 0;
    fd = 0;
`endif
    if (rst) begin
      hz = 0; f1 = 0; f2 = 0; fd = 0;
    end
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, g_alu});
    chk("ld_ready", {31'b0, ld_ready}, {31'b0, g_ld});
    chk("hazard", {31'b0, hazard}, {31'b0, hz});
    chk("fwd_rs1_en", {31'b0, fwd_rs1_en}, {31'b0, f1});
    chk("fwd_rs2_en", {31'b0, fwd_rs2_en}, {31'b0, f2});
    chk("fwd_data", fwd_data, fd);

    @(posedge clk);
    if (rst) begin
      m_last_was_load = 1;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_wen  = 0;
      m_rd   = 0;
      m_data = 0;
    end else begin
      w_rd   = g_alu ? alu_rd : ld_rd;
      w_data = g_alu ? alu_data : ld_data;
      m_wen  = (g_alu || g_ld) && w_rd != 0;
      if (m_wen) begin
        m_rd   = w_rd;
        m_data = w_data;
      end
      if (g_alu) m_last_was_load = 0;
      if (g_ld)  m_last_was_load = 1;
      if (g_ld && ld_rd != 0) m_pend[ld_rd] = 0;
      if (iss_load && iss_rd != 0) m_pend[iss_rd] = 1;
    end
    #1;
    chk("rf_wr_en", {31'b0, rf_wr_en}, {31'b0, m_wen});
    chk("rf_rd", {27'b0, rf_rd}, {27'b0, m_rd});
    chk("rf_wr_data", rf_wr_data, m_data);
  endtask

  initial begin
    m_last_was_load = 1;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_wen = 0; m_rd = 0; m_data = 0;
    rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    iss_load = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    step(); step();
    rst = 0;
    step();

    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    chk("first_write_data", rf_wr_data, 32'hDEADBEEF);
    alu_valid = 0;
    step(); step();

    alu_valid = 1; alu_rd = 1; alu_data = 32'h1111_0001;
    ld_valid  = 1; ld_rd  = 2; ld_data  = 32'h2222_0002;
    repeat (4) step();
    alu_valid = 0; ld_valid = 0;
    step();

    iss_load = 1; iss_rd = 7;
    step();
    iss_load = 0; rs1 = 7;
    repeat (3) step();
    ld_valid = 1; ld_rd = 7; ld_data = 32'h0700_0007;
    step();
    ld_valid = 0;
    repeat (2) step();
    rs1 = 0;

    alu_valid = 1; alu_rd = 0; alu_data = 32'hBAD0_0000;
    step();
    alu_valid = 0;
    step();

    ld_valid = 1; ld_rd = 9; ld_data = 32'h0909_0909;
    step();
    ld_valid = 0; rs2 = 9;
    step(); step();
    rs2 = 0;

    iss_load = 1; iss_rd = 3;
    step();
    iss_load = 0; alu_valid = 1; alu_rd = 4; alu_data = 32'h4444_4444;
    step();
    rst = 1; alu_valid = 0;
    step();
    rst = 0; rs1 = 3;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h6666_6666;
    ld_valid  = 1; ld_rd  = 8; ld_data  = 32'h8888_8888;
    step(); step();
    alu_valid = 0; ld_valid = 0; rs1 = 0;
    step();

    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      alu_valid = $urandom_range(0, 1);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = $urandom_range(0, 1);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      iss_load  = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
